// File: rtl/ecg_window_buffer.sv
// ecg_window_buffer: ping-pong framer collecting ECG samples into fixed windows for the classifier
module ecg_window_buffer #(
    parameter int DATA_W = 8,
    parameter int WIN_LEN = 15,
    localparam int ADDR_W = $clog2(WIN_LEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              win_start,
    output logic              win_busy,
    input  logic              win_done,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [15:0]       win_count
);
    typedef enum logic [1:0] {FILL, WAIT, SWAP} state_t;
    state_t state;
    logic [DATA_W-1:0] mem [2][WIN_LEN];
    logic [ADDR_W-1:0] wr_ptr;
    logic wr_bank, rd_bank;
    logic accept, last, rd_free;
    assign s_ready = state == FILL && !rst;
    assign accept = s_valid && s_ready;
    assign last = wr_ptr == ADDR_W'(WIN_LEN - 1);
    assign rd_free = !win_busy || win_done;
    always_ff @(posedge clk)
        if (accept) mem[wr_bank][wr_ptr] <= s_data;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FILL;
            wr_ptr <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b1;
            win_start <= 1'b0;
            win_busy <= 1'b0;
            win_count <= '0;
            rd_data <= '0;
        end else begin
            win_start <= 1'b0;
            rd_data <= int'(rd_addr) < WIN_LEN ? mem[rd_bank][rd_addr] : '0;
            if (win_busy && win_done) win_busy <= 1'b0;
            case (state)
                FILL: if (accept) begin
                    wr_ptr <= wr_ptr + 1'b1;
                    if (last) state <= rd_free ? SWAP : WAIT;
                end
                WAIT: if (rd_free) state <= SWAP;
                default: begin
                    // hand the filled bank to the reader; the set of win_busy overrides any release above
                    rd_bank <= wr_bank;
                    wr_bank <= !wr_bank;
                    wr_ptr <= '0;
                    win_busy <= 1'b1;
                    win_start <= 1'b1;
                    win_count <= win_count + 1'b1;
                    state <= FILL;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ecg_window_buffer.sv
// tb_ecg_window_buffer: directed and randomized checks of the window buffer against a queue model
module tb_ecg_window_buffer;
    localparam int DATA_W = 8;
    localparam int WIN_LEN = 15;
    localparam int ADDR_W = $clog2(WIN_LEN);
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic s_valid = 1'b0;
    logic win_done = 1'b0;
    logic [DATA_W-1:0] s_data = '0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic s_ready, win_start, win_busy;
    logic [DATA_W-1:0] rd_data;
    logic [15:0] win_count;
    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] win_exp[WIN_LEN];
    logic [7:0] p1[WIN_LEN], p2[WIN_LEN], p3[WIN_LEN], p4[WIN_LEN];
    int w, cyc, wins, rel, sent, rc, dly;
    logic acc;

    always #5 clk = ~clk;

    ecg_window_buffer dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .win_start(win_start), .win_busy(win_busy), .win_done(win_done),
        .rd_addr(rd_addr), .rd_data(rd_data), .win_count(win_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        s_valid = 1'b0;
        win_done = 1'b0;
        #1;
        check("rst_ready", 32'(s_ready), 0);
        check("rst_start", 32'(win_start), 0);
        check("rst_busy", 32'(win_busy), 0);
        check("rst_rdata", 32'(rd_data), 0);
        check("rst_count", 32'(win_count), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rel_ready", 32'(s_ready), 1);
        exp_q.delete();
    endtask

    task automatic send(input logic [7:0] d, output int waited);
        waited = 0;
        s_valid = 1'b1;
        s_data = d;
        while (!s_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!s_ready) check("send_timeout", 32'(s_ready), 1);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic read_win(input string tag, input logic [7:0] ref_w[WIN_LEN]);
        for (int i = 0; i < WIN_LEN; i++) begin
            rd_addr = ADDR_W'(i);
            @(negedge clk);
            check($sformatf("%s[%0d]", tag, i), 32'(rd_data), 32'(ref_w[i]));
        end
    endtask

    initial begin
        p1 = '{8'h10, 8'h0F, 8'h07, 8'h03, 8'h00, 8'h03, 8'h05, 8'h06, 8'h06, 8'h07,
               8'h07, 8'h07, 8'h07, 8'h07, 8'h07};
        for (int i = 0; i < WIN_LEN; i++) begin
            p2[i] = 8'($urandom);
            p3[i] = 8'($urandom);
            p4[i] = 8'($urandom);
        end
        // T1: first window, start latency and readback
        do_reset();
        for (int i = 0; i < WIN_LEN; i++) send(p1[i], w);
        check("t1_swap_start", 32'(win_start), 0);
        check("t1_swap_ready", 32'(s_ready), 0);
        @(negedge clk);
        check("t1_start", 32'(win_start), 1);
        check("t1_count", 32'(win_count), 1);
        check("t1_busy", 32'(win_busy), 1);
        rd_addr = '0;
        @(negedge clk);
        check("t1_pulse_end", 32'(win_start), 0);
        check("t1_ready", 32'(s_ready), 1);
        read_win("t1_rd", p1);
        // T2: second window completes while the first is still owned
        for (int i = 0; i < WIN_LEN; i++) send(p2[i], w);
        check("t2_ready_low", 32'(s_ready), 0);
        rd_addr = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t2_nostart", 32'(win_start), 0);
            check("t2_wait_ready", 32'(s_ready), 0);
            check("t2_stable", 32'(rd_data), 32'(p1[0]));
        end
        win_done = 1'b1;
        @(negedge clk);
        win_done = 1'b0;
        check("t2_swap_start", 32'(win_start), 0);
        check("t2_busy_clr", 32'(win_busy), 0);
        @(negedge clk);
        check("t2_start", 32'(win_start), 1);
        check("t2_count", 32'(win_count), 2);
        read_win("t2_rd", p2);
        // T3: release coincides with the last accept of the next window
        for (int i = 0; i < WIN_LEN - 1; i++) begin
            send(p3[i], w);
            check("t3_nostall", w, 0);
        end
        win_done = 1'b1;
        send(p3[WIN_LEN-1], w);
        win_done = 1'b0;
        check("t3_last_nostall", w, 0);
        check("t3_swap_start", 32'(win_start), 0);
        check("t3_swap_ready", 32'(s_ready), 0);
        @(negedge clk);
        check("t3_start", 32'(win_start), 1);
        check("t3_ready", 32'(s_ready), 1);
        check("t3_count", 32'(win_count), 3);
        read_win("t3_rd", p3);
        // T4: reset mid-window discards the partial window
        for (int i = 0; i < 7; i++) send(8'($urandom), w);
        do_reset();
        for (int i = 0; i < WIN_LEN; i++) send(p4[i], w);
        @(negedge clk);
        check("t4_start", 32'(win_start), 1);
        check("t4_count", 32'(win_count), 1);
        read_win("t4_rd", p4);
        // T5: random gaps and release delays against the queue model
        do_reset();
        cyc = 0; wins = 0; rel = 0; sent = 0; rc = -1; dly = -1; acc = 1'b0;
        while (rel < 100 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            win_done = 1'b0;
            if (rc > 0) begin
                check($sformatf("t5_w%0d_rd%0d", wins, rc - 1), 32'(rd_data), 32'(win_exp[rc-1]));
                check("t5_busy", 32'(win_busy), 1);
            end
            if (rc == WIN_LEN) begin
                rc = -1;
                dly = $urandom_range(0, 20);
            end else if (rc >= 0) begin
                rd_addr = ADDR_W'(rc);
                rc++;
            end else if (dly == 0) begin
                win_done = 1'b1;
                dly = -1;
                rel++;
            end else if (dly > 0) dly--;
            if (win_start) begin
                wins++;
                check("t5_count", 32'(win_count), wins);
                check("t5_qsize", 32'(exp_q.size() >= WIN_LEN), 1);
                for (int i = 0; i < WIN_LEN; i++) win_exp[i] = exp_q.size() > 0 ? exp_q.pop_front() : 8'h00;
                rc = 0;
            end
            if (!(s_valid && !acc)) begin
                s_valid = sent < 100 * WIN_LEN && $urandom_range(0, 3) != 0;
                s_data = 8'($urandom);
            end
            acc = s_valid && s_ready;
            if (acc) begin
                exp_q.push_back(s_data);
                sent++;
            end
        end
        check("t5_released", rel, 100);
        check("t5_windows", wins, 100);
        check("t5_count_final", 32'(win_count), 100);
        check("t5_leftover", exp_q.size(), 0);
        // T6: stray release while idle and out-of-range read
        @(negedge clk);
        win_done = 1'b0;
        s_valid = 1'b0;
        rd_addr = ADDR_W'(15);
        @(negedge clk);
        check("t6_idle_busy", 32'(win_busy), 0);
        win_done = 1'b1;
        @(negedge clk);
        win_done = 1'b0;
        check("t6_busy", 32'(win_busy), 0);
        check("t6_start", 32'(win_start), 0);
        check("t6_count", 32'(win_count), 100);
        check("t6_ready", 32'(s_ready), 1);
        check("t6_rdata", 32'(rd_data), 0);
        @(negedge clk);
        check("t6_start2", 32'(win_start), 0);
        check("t6_rdata2", 32'(rd_data), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
